display_mux_4dig: RTL
=====================

DISPLAY_MUX_4DIG -- requirements
Module: display_mux_4dig

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clocks per digit slot (1 kHz slot rate at 50 MHz); SHALL be >= 4.
REQ-002 Parameter BLANK_CYCLES, default 64, all-off clocks at the start of each slot; SHALL be < SCAN_DIV.
REQ-003 Parameter ACTIVE_LOW, default 1; 1 = seg, dp and an asserted low, 0 = asserted high.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 value_in  input  16  four hex nibbles; nibble k = value_in[4k+3:4k], digit 0 rightmost.
REQ-007 value_valid  input  1  producer offers value_in.
REQ-008 value_ready  output  1  block can accept value_in.
REQ-009 dp_in  input  4  decimal point per digit, bit k = digit k; sampled with value_in.
REQ-010 blank_lz  input  1  level; 1 = suppress leading zeros.
REQ-011 seg  output  7  segments, seg[0]=a ... seg[6]=g.
REQ-012 dp  output  1  decimal point of the active digit.
REQ-013 an  output  4  digit enables, an[k] = digit k; at most one asserted.
REQ-014 frame_done  output  1  one-cycle pulse at the end of the digit-3 slot.

Function
REQ-015 Prescaler SHALL count 0..SCAN_DIV-1 and wrap to 0; digit index SHALL advance 0->1->2->3->0 on each prescaler wrap.
REQ-016 Transfer SHALL occur on value_valid && value_ready at a rising edge: value_in and dp_in are captured into a pending register and pending_full is set.
REQ-017 value_ready SHALL equal !pending_full && !reset.
REQ-018 In the frame_done cycle with pending_full set, the display register SHALL load from pending and pending_full SHALL clear, so displayed data only changes at frame boundaries (no tearing).
REQ-019 A transfer in the frame_done cycle with pending empty SHALL fill pending and be displayed at the following frame boundary.
REQ-020 frame_done SHALL be 1 exactly in the cycle where the prescaler is SCAN_DIV-1 and the digit index is 3.
REQ-021 When the prescaler is < BLANK_CYCLES, all an, seg and dp SHALL be inactive (anti-ghosting).
REQ-022 Otherwise an[digit] SHALL be active, seg SHALL be the hex decode of the display nibble, and dp SHALL be the displayed dp bit.
REQ-023 Hex decode SHALL use standard glyphs:
- 0-9
- A
- b
- C
- d
- E
- F
REQ-024 With blank_lz=1, digit k (k>=1) SHALL be fully blanked (an, seg and dp inactive) when display nibbles k..3 are all zero; digit 0 SHALL never be blanked.
REQ-025 an, seg and dp SHALL be registered, reflecting the prescaler, digit and display state of the previous cycle (1-cycle latency); frame_done SHALL be combinational from current state.
REQ-026 Polarity inversion per ACTIVE_LOW SHALL be applied only at the output registers.

Reset
REQ-027 While reset=1 at a clock edge, the block SHALL clear to:
- prescaler 0, digit 0
- display register 0x0000, display dp 0
- pending_full 0
REQ-028 With reset=1, the outputs SHALL be:
- value_ready 0, frame_done 0
- an, seg and dp inactive in the following cycle
REQ-029 Reset asserted mid-slot or mid-handshake SHALL discard pending data; no transfer SHALL occur in a cycle with reset=1.

Verification (SCAN_DIV=8, BLANK_CYCLES=2, ACTIVE_LOW=1)
REQ-030 Reset scenario: hold reset 3 cycles, then release.
- During reset: an=4'b1111, value_ready=0.
- 3 cycles after release: an=4'b1110, seg=7'b1000000 ("0").
REQ-031 Handshake scenario: offer 0x12AF with dp_in=4'b0100 mid-frame.
- value_ready drops the next cycle.
- Display is unchanged until frame_done.
- After frame_done, the digits show F, A, 2, 1 with dp on digit 2, and value_ready returns to 1.
REQ-032 Back-to-back scenario: hold value_valid with 0x1111 and then 0x2222.
- The second value is held off until the frame boundary.
- Each accepted value is displayed for at least one full frame.
- No value is lost.
REQ-033 Leading-zero scenario: display 0x0030 with blank_lz=1.
- Digits 3 and 2 are blanked.
- Digits 1 and 0 show "3" and "0".
- 0x0000 shows only digit 0 ("0").
REQ-034 Scan-timing scenario: check each 8-cycle slot.
- Slot timing: 2 all-off cycles followed by 6 active cycles.
- an sequence over a frame: 1110, 1101, 1011, 0111.
- frame_done: 1 pulse per 32 cycles.
REQ-035 Reset-mid-operation scenario: assert reset during digit 2 with pending_full=1.
- After release: display=0x0000, pending is empty, and the scan restarts at digit 0.

Source files
------------

// File: rtl/display_mux_4dig.sv
// display_mux_4dig: 4-digit hex 7-segment scanner with tear-free frame-boundary updates
module display_mux_4dig #(
  parameter int SCAN_DIV = 50000,
  parameter int BLANK_CYCLES = 64,
  parameter bit ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value_in,
  input  logic        value_valid,
  output logic        value_ready,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_done
);
  localparam int PW = $clog2(SCAN_DIV);
  logic [PW-1:0] presc;
  logic [1:0]    digit;
  logic [15:0]   pend_val, disp_val, upper;
  logic [3:0]    pend_dp, disp_dp, nib, an_raw;
  logic [6:0]    glyph, seg_raw;
  logic          pend_full, xfer, slot_end, blank, dp_raw;
  assign slot_end    = presc == PW'(SCAN_DIV - 1);
  assign frame_done  = slot_end && digit == 2'd3 && !reset;
  assign value_ready = !pend_full && !reset;
  assign xfer        = value_valid && value_ready;
  assign upper       = disp_val >> {digit, 2'b00};
  assign nib         = upper[3:0];
  assign blank       = presc < PW'(BLANK_CYCLES) || (blank_lz && digit != 2'd0 && upper == 16'd0);
  assign an_raw      = blank ? 4'b0000 : 4'b0001 << digit;
  assign seg_raw     = blank ? 7'd0 : glyph;
  assign dp_raw      = !blank && disp_dp[digit];
  // hex nibble to active-high glyph, bit 0 = segment a
  always_comb begin
    glyph = 7'h00;
    case (nib)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  end
  // slot prescaler and digit index, digit advancing on each prescaler wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      digit <= 2'd0;
    end else begin
      presc <= slot_end ? '0 : presc + 1'b1;
      digit <= slot_end ? digit + 2'd1 : digit;
    end
  end
  // pending buffer accepts new data; display only reloads at the frame boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_full <= 1'b0;
      disp_val  <= 16'd0;
      disp_dp   <= 4'd0;
    end else if (xfer) begin
      pend_val  <= value_in;
      pend_dp   <= dp_in;
      pend_full <= 1'b1;
    end else if (frame_done && pend_full) begin
      disp_val  <= pend_val;
      disp_dp   <= pend_dp;
      pend_full <= 1'b0;
    end
  end
  // registered pin drivers with polarity applied last
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= {4{ACTIVE_LOW}};
      seg <= {7{ACTIVE_LOW}};
      dp  <= ACTIVE_LOW;
    end else begin
      an  <= an_raw ^ {4{ACTIVE_LOW}};
      seg <= seg_raw ^ {7{ACTIVE_LOW}};
      dp  <= dp_raw ^ ACTIVE_LOW;
    end
  end
endmodule
